// File: rtl/usb_fifo_write_arbiter_if.sv
// usb_fifo_write_arbiter_if: source FIFO and FX2 slave-FIFO signals for the EP6 write arbiter
//   slave  : arbiter side (consumes source heads and counts, drives pops and FX2 pins)
//   master : environment side (capture FIFOs and FX2 model)
interface usb_fifo_write_arbiter_if;
  logic [15:0] s0_data;
  logic [7:0]  s0_count;
  logic        s0_pop;
  logic [15:0] s1_data;
  logic [7:0]  s1_count;
  logic        s1_pop;
  logic        u_flagb;
  logic [15:0] u_data_out;
  logic        u_slwr;
  logic        u_pktend;
  logic [1:0]  u_fifoadr;
  logic        u_slcs;
  logic        busy;
  modport slave (
    input  s0_data, s0_count, s1_data, s1_count, u_flagb,
    output s0_pop, s1_pop, u_data_out, u_slwr, u_pktend, u_fifoadr, u_slcs, busy
  );
  modport master (
    output s0_data, s0_count, s1_data, s1_count, u_flagb,
    input  s0_pop, s1_pop, u_data_out, u_slwr, u_pktend, u_fifoadr, u_slcs, busy
  );
endinterface

// File: rtl/usb_fifo_write_arbiter.sv
// usb_fifo_write_arbiter: round-robin share of the FX2 EP6 write port between two sources
//   clk, rst (sync, active-low); bus.slave carries source heads/counts/pops and the FX2 pins
//   Each grant emits one header word then up to BURST_LEN data words; short packets are
//   committed with PKTEND after IDLE_TIMEOUT idle cycles.
module usb_fifo_write_arbiter #(
  parameter int BURST_LEN    = 255,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  usb_fifo_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, PKTEND} state_t;
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam logic [7:0] BL = 8'(BURST_LEN);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  state_t state_q, state_d;
  logic ch_q, ch_d, rr_q, rr_d;
  logic [7:0] rem_q, rem_d, pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] data_q, data_d;
  logic slwr_q, slwr_d, pktend_q, pktend_d;
  logic e0, e1, src, pop;
  logic [7:0] cnt;
  logic [15:0] head;
  assign e0 = bus.s0_count != 8'd0;
  assign e1 = bus.s1_count != 8'd0;
  assign src = (e0 && e1) ? rr_q : e1;
  assign cnt = src ? bus.s1_count : bus.s0_count;
  assign head = ch_q ? bus.s1_data : bus.s0_data;
  // pops follow FLAGB in the same cycle so the head word is consumed exactly when written
  assign pop = rst && state_q == DATA && bus.u_flagb;
  assign bus.s0_pop = pop && !ch_q;
  assign bus.s1_pop = pop && ch_q;
  assign bus.u_data_out = data_q;
  assign bus.u_slwr = slwr_q;
  assign bus.u_pktend = pktend_q;
  assign bus.u_fifoadr = 2'b10;
  assign bus.u_slcs = 1'b0;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    rr_d = rr_q;
    rem_d = rem_q;
    pkt_cnt_d = pkt_cnt_q;
    idle_cnt_d = '0;
    data_d = data_q;
    slwr_d = 1'b1;
    pktend_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (e0 || e1) begin
          ch_d = src;
          rem_d = cnt > BL ? BL : cnt;
          state_d = HDR;
        end else if (pkt_cnt_q != 8'd0) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            state_d = PKTEND;
          end
        end
      end
      HDR: begin
        if (bus.u_flagb) begin
          data_d = {4'hA, 3'b000, ch_q, rem_q};
          slwr_d = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.u_flagb) begin
          data_d = head;
          slwr_d = 1'b0;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            rr_d = !ch_q;
            state_d = IDLE;
          end
        end
      end
      PKTEND: begin
        if (bus.u_flagb) begin
          pktend_d = 1'b0;
          pkt_cnt_d = 8'd0;
          state_d = IDLE;
        end
      end
    endcase
    // every written word advances the packet fill level; a wrap is a full 512-byte packet
    if (!slwr_d) pkt_cnt_d = pkt_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q <= 1'b0;
      rr_q <= 1'b0;
      rem_q <= 8'd0;
      pkt_cnt_q <= 8'd0;
      idle_cnt_q <= '0;
      data_q <= 16'hFFFF;
      slwr_q <= 1'b1;
      pktend_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      rr_q <= rr_d;
      rem_q <= rem_d;
      pkt_cnt_q <= pkt_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q <= data_d;
      slwr_q <= slwr_d;
      pktend_q <= pktend_d;
    end
  end
endmodule

// File: tb/tb_usb_fifo_write_arbiter.sv
// tb_usb_fifo_write_arbiter: scoreboard bench for the EP6 write arbiter
module tb_usb_fifo_write_arbiter;
  localparam int BURST_LEN = 255;
  localparam logic [16:0] PKTEND_MARK = 17'h10000;
  logic clk, rst;
  usb_fifo_write_arbiter_if bus();
  usb_fifo_write_arbiter #(.BURST_LEN(BURST_LEN), .IDLE_TIMEOUT(1024)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks, errors, cyc, exp_rd, last_word_cyc, pktend_cyc, pulses, add0, add1;
  int m[2];
  logic rr, mon_en, flag_rand;
  logic [7:0] pkt;
  logic [16:0] exp[$];
  logic [15:0] q0[$], q1[$];
  function automatic logic [15:0] word(input logic ch, input int k);
    return {ch, 15'(k)} ^ 16'h3C5A;
  endfunction
  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        check("strobe_overlap", {16'b0, bus.u_slwr | bus.u_pktend}, 17'd1);
        if (!bus.u_slwr) begin
          if (exp_rd < exp.size()) begin
            check("word", {1'b0, bus.u_data_out}, exp[exp_rd]);
            exp_rd++;
          end else fail("unexpected_word", int'(bus.u_data_out));
          last_word_cyc = cyc;
        end
        if (!bus.u_pktend) begin
          if (exp_rd < exp.size()) begin
            check("pktend", PKTEND_MARK, exp[exp_rd]);
            exp_rd++;
          end else fail("unexpected_pktend", cyc);
          pulses++;
          pktend_cyc = cyc;
        end
      end
    end
  endtask
  task automatic sources();
    logic p0, p1, fb;
    int k0, k1;
    k0 = 0;
    k1 = 0;
    forever begin
      @(posedge clk);
      p0 = bus.s0_pop;
      p1 = bus.s1_pop;
      fb = bus.u_flagb;
      #1;
      if (p0 || p1) begin
        check("pop_needs_flagb", {16'b0, fb}, 17'd1);
        check("pop_one_hot", {16'b0, p0 & p1}, 17'd0);
      end
      if (p0) begin
        if (q0.size() > 0) void'(q0.pop_front());
        else fail("pop_empty_s0", cyc);
      end
      if (p1) begin
        if (q1.size() > 0) void'(q1.pop_front());
        else fail("pop_empty_s1", cyc);
      end
      repeat (add0) begin q0.push_back(word(1'b0, k0)); k0++; end
      repeat (add1) begin q1.push_back(word(1'b1, k1)); k1++; end
      bus.s0_count = q0.size() > 255 ? 8'd255 : 8'(q0.size());
      bus.s1_count = q1.size() > 255 ? 8'd255 : 8'(q1.size());
      bus.s0_data = q0.size() > 0 ? q0[0] : 16'h0000;
      bus.s1_data = q1.size() > 0 ? q1[0] : 16'h0000;
    end
  endtask
  task automatic flag_drv();
    forever begin
      @(negedge clk);
      bus.u_flagb = flag_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask
  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while ((exp_rd != exp.size() || bus.busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) fail("drain_timeout", t);
  endtask
  // reference: both sources are loaded at once, so the burst order follows purely from
  // round-robin over the remaining word counts
  task automatic batch(input int n0, input int n1);
    int r[2];
    int n;
    logic c;
    r[0] = n0;
    r[1] = n1;
    while (r[0] > 0 || r[1] > 0) begin
      c = (r[0] > 0 && r[1] > 0) ? rr : (r[1] > 0);
      n = r[c] > 255 ? 255 : r[c];
      n = n > BURST_LEN ? BURST_LEN : n;
      exp.push_back({1'b0, 4'hA, 3'b000, c, 8'(n)});
      for (int i = 0; i < n; i++) begin
        exp.push_back({1'b0, word(c, m[c])});
        m[c]++;
      end
      r[c] -= n;
      rr = !c;
      pkt = pkt + 8'(n + 1);
    end
    @(negedge clk);
    add0 = n0;
    add1 = n1;
    @(negedge clk);
    add0 = 0;
    add1 = 0;
    wait_drain(3000);
  endtask
  task automatic gap(input bit long_gap);
    if (long_gap) begin
      if (pkt != 8'd0) begin
        exp.push_back(PKTEND_MARK);
        pkt = 8'd0;
      end
      repeat (1100) @(negedge clk);
      wait_drain(400);
    end else repeat ($urandom_range(0, 20)) @(negedge clk);
  endtask
  initial begin
    int n0, n1, pulses_before;
    checks = 0; errors = 0; cyc = 0; exp_rd = 0; last_word_cyc = 0; pktend_cyc = 0; pulses = 0;
    add0 = 0; add1 = 0; m[0] = 0; m[1] = 0; rr = 1'b0; pkt = 8'd0;
    mon_en = 1'b0; flag_rand = 1'b0; rst = 1'b0;
    bus.u_flagb = 1'b1;
    bus.s0_count = 8'd0; bus.s1_count = 8'd0; bus.s0_data = 16'h0; bus.s1_data = 16'h0;
    fork
      monitor();
      sources();
      flag_drv();
    join_none
    repeat (3) @(negedge clk);
    check("rst_data", {1'b0, bus.u_data_out}, 17'h0FFFF);
    check("rst_slwr", {16'b0, bus.u_slwr}, 17'd1);
    check("rst_pktend", {16'b0, bus.u_pktend}, 17'd1);
    check("rst_busy", {16'b0, bus.busy}, 17'd0);
    check("fifoadr", {15'b0, bus.u_fifoadr}, 17'd2);
    check("slcs", {16'b0, bus.u_slcs}, 17'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    batch(3, 0);
    gap(1'b0);
    batch(255, 255);
    batch(10, 10);
    flag_rand = 1'b1;
    batch(10, 0);
    gap(1'b0);
    for (int i = 0; i < 14; i++) begin
      n0 = $urandom_range(0, 400);
      n1 = $urandom_range(0, 400);
      if (n0 == 0 && n1 == 0) n0 = 1;
      batch(n0, n1);
      gap($urandom_range(0, 3) == 0);
    end
    flag_rand = 1'b0;
    gap(1'b1);
    batch(0, 5);
    gap(1'b1);
    check("pktend_latency", 17'(pktend_cyc - last_word_cyc), 17'd1025);
    pulses_before = pulses;
    batch(255, 0);
    gap(1'b1);
    check("no_pktend_full_pkt", 17'(pulses), 17'(pulses_before));
    mon_en = 1'b0;
    @(negedge clk);
    add0 = 100;
    @(negedge clk);
    add0 = 0;
    repeat (20) @(negedge clk);
    check("mid_burst_busy", {16'b0, bus.busy}, 17'd1);
    rst = 1'b0;
    #1;
    check("rst_pop", {15'b0, bus.s0_pop, bus.s1_pop}, 17'd0);
    @(negedge clk);
    check("rst_mid_data", {1'b0, bus.u_data_out}, 17'h0FFFF);
    check("rst_mid_slwr", {16'b0, bus.u_slwr}, 17'd1);
    check("rst_mid_pktend", {16'b0, bus.u_pktend}, 17'd1);
    check("rst_mid_busy", {16'b0, bus.busy}, 17'd0);
    check("rst_mid_pop", {15'b0, bus.s0_pop, bus.s1_pop}, 17'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
